pbl_request_sequencer: RTL and testbench

PBL_REQUEST_SEQUENCER -- requirements
Module: pbl_request_sequencer

---
 rtl/pbl_request_sequencer.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_pbl_request_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pbl_request_sequencer.sv
// Purpose : debounces two users' push-buttons, captures each user's switch code on a
//           press and presents pending requests to the access checker in rounds.
// Latency : stable raw key change -> PEND set in DEBOUNCE_CYCLES+3 cycles; a round
//           is HOLD_CYCLES VALID cycles followed by one idle RELEASE cycle.
// Backpressure: none; a press for a user whose request is still pending is
//           discarded and reported on DROP.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   SW0, SW1       raw switches per user: [3:1] authentication code, [0] function bit
//   KEY0, KEY1     raw active-low push-buttons per user (2'b11 = nothing pressed)
//   HH0, HH1       registered request code presented to the access checker
//   B0, B1         registered button pattern presented (idle 2'b11)
//   VALID          high while a request round is presented
//   PEND           pending flags, [0] user 0, [1] user 1
//   DROP           one-cycle pulse when a press is discarded for an already pending user
//
// Build option: define PBL_PAIR_WINDOW_EN to build the WAIT_PAIR state, which holds a
// lone pending request for up to PAIR_WINDOW cycles so both users can be presented
// together. Without it PAIR_WINDOW has no effect and any pending request is presented
// immediately.

module pbl_request_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES     = 8,
    parameter int unsigned PAIR_WINDOW     = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] SW0,
    input  logic [3:0] SW1,
    input  logic [1:0] KEY0,
    input  logic [1:0] KEY1,
    output logic [3:0] HH0,
    output logic [3:0] HH1,
    output logic [1:0] B0,
    output logic [1:0] B1,
    output logic       VALID,
    output logic [1:0] PEND,
    output logic [1:0] DROP
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_PAIR = 2'd1,
        ST_PRESENT   = 2'd2,
        ST_RELEASE   = 2'd3
    } state_t;

    localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0][3:0]  sw_s1_q,    sw_s1_d;
    logic [1:0][3:0]  sw_s2_q,    sw_s2_d;
    logic [1:0][1:0]  key_s1_q,   key_s1_d;
    logic [1:0][1:0]  key_s2_q,   key_s2_d;
    logic [1:0][1:0]  key_last_q, key_last_d;
    logic [1:0][1:0]  deb_q,      deb_d;
    logic [1:0][15:0] db_cnt_q,   db_cnt_d;
    logic [1:0]       press_q,    press_d;

    logic [1:0][3:0]  req_sw_q,   req_sw_d;
    logic [1:0][1:0]  req_key_q,  req_key_d;
    logic [1:0]       pend_q,     pend_d;
    logic [1:0]       drop_q,     drop_d;

    state_t           state_q,    state_d;
    logic [1:0]       pres_q,     pres_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [1:0][3:0]  hh_q,       hh_d;
    logic [1:0][1:0]  b_q,        b_d;
    logic             valid_q,    valid_d;

`ifdef PBL_PAIR_WINDOW_EN
    localparam logic [15:0] PW_LAST = 16'(PAIR_WINDOW - 1);
    logic [15:0]      pair_cnt_q, pair_cnt_d;
`endif

    logic [1:0]       pend_clr;
    logic             launch;

    // ------------------------------------------------------------------
    // Synchronizers and debouncers
    // ------------------------------------------------------------------
    always_comb begin
        sw_s1_d    = {SW1, SW0};
        sw_s2_d    = sw_s1_q;
        key_s1_d   = {KEY1, KEY0};
        key_s2_d   = key_s1_q;
        key_last_d = key_s2_q;
        deb_d      = deb_q;
        db_cnt_d   = db_cnt_q;
        press_d    = 2'b00;
        for (int u = 0; u < 2; u++) begin
            if (key_s2_q[u] == deb_q[u]) begin
                db_cnt_d[u] = 16'd0;
            end else if (key_s2_q[u] != key_last_q[u]) begin
                // A new differing value (or a bounce between two pressed patterns)
                // starts the stability count again; this cycle is the first one.
                db_cnt_d[u] = 16'd1;
            end else if (db_cnt_q[u] == DB_LAST) begin
                deb_d[u]    = key_s2_q[u];
                db_cnt_d[u] = 16'd0;
                // Only leaving the released pattern is a press; releases and
                // pattern changes while held are not events.
                press_d[u]  = (deb_q[u] == 2'b11);
            end else begin
                db_cnt_d[u] = db_cnt_q[u] + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request capture, pending flags and drop reporting
    // ------------------------------------------------------------------
    always_comb begin
        req_sw_d  = req_sw_q;
        req_key_d = req_key_q;
        pend_d    = pend_q & ~pend_clr;
        drop_d    = 2'b00;
        for (int u = 0; u < 2; u++) begin
            if (press_q[u]) begin
                // A press landing in the same cycle its flag is being cleared
                // still counts as a fresh request.
                if (!pend_q[u] || pend_clr[u]) begin
                    req_sw_d[u]  = sw_s2_q[u];
                    req_key_d[u] = deb_q[u];
                    pend_d[u]    = 1'b1;
                end else begin
                    drop_d[u] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Presentation FSM (outputs are loaded on entry to PRESENT and held)
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pres_d     = pres_q;
        hold_cnt_d = hold_cnt_q;
        hh_d       = hh_q;
        b_d        = b_q;
        valid_d    = valid_q;
        pend_clr   = 2'b00;
        launch     = 1'b0;
`ifdef PBL_PAIR_WINDOW_EN
        pair_cnt_d = pair_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (pend_q != 2'b00) begin
`ifdef PBL_PAIR_WINDOW_EN
                    if (pend_q == 2'b11) begin
                        launch = 1'b1;
                    end else begin
                        state_d    = ST_WAIT_PAIR;
                        pair_cnt_d = 16'd0;
                    end
`else
                    launch = 1'b1;
`endif
                end
            end
`ifdef PBL_PAIR_WINDOW_EN
            ST_WAIT_PAIR: begin
                if (pend_q == 2'b11 || pair_cnt_q == PW_LAST) begin
                    launch = 1'b1;
                end else begin
                    pair_cnt_d = pair_cnt_q + 16'd1;
                end
            end
`endif
            ST_PRESENT: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RELEASE;
                    valid_d = 1'b0;
                    hh_d    = '0;
                    b_d     = {2'b11, 2'b11};
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            ST_RELEASE: begin
                pend_clr = pres_q;
                pres_d   = 2'b00;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The set of users presented is frozen here; later presses wait for
        // the next round.
        if (launch) begin
            state_d    = ST_PRESENT;
            pres_d     = pend_q;
            hold_cnt_d = 8'd0;
            valid_d    = 1'b1;
            for (int u = 0; u < 2; u++) begin
                hh_d[u] = pend_q[u] ? req_sw_q[u]  : 4'b0000;
                b_d[u]  = pend_q[u] ? req_key_q[u] : 2'b11;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            key_s1_q   <= '1;
            key_s2_q   <= '1;
            key_last_q <= '1;
            deb_q      <= '1;
            db_cnt_q   <= '0;
            press_q    <= 2'b00;
            req_sw_q   <= '0;
            req_key_q  <= '1;
            pend_q     <= 2'b00;
            drop_q     <= 2'b00;
            state_q    <= ST_IDLE;
            pres_q     <= 2'b00;
            hold_cnt_q <= 8'd0;
            hh_q       <= '0;
            b_q        <= '1;
            valid_q    <= 1'b0;
        end else begin
            sw_s1_q    <= sw_s1_d;
            sw_s2_q    <= sw_s2_d;
            key_s1_q   <= key_s1_d;
            key_s2_q   <= key_s2_d;
            key_last_q <= key_last_d;
            deb_q      <= deb_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
            req_sw_q   <= req_sw_d;
            req_key_q  <= req_key_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
            state_q    <= state_d;
            pres_q     <= pres_d;
            hold_cnt_q <= hold_cnt_d;
            hh_q       <= hh_d;
            b_q        <= b_d;
            valid_q    <= valid_d;
        end
    end

`ifdef PBL_PAIR_WINDOW_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_cnt_q <= 16'd0;
        end else begin
            pair_cnt_q <= pair_cnt_d;
        end
    end
`else
    // Pairing is not built; PAIR_WINDOW has no effect in this configuration.
    if (PAIR_WINDOW == 0) begin : g_pair_window_unused
    end
`endif

    assign HH0   = hh_q[0];
    assign HH1   = hh_q[1];
    assign B0    = b_q[0];
    assign B1    = b_q[1];
    assign VALID = valid_q;
    assign PEND  = pend_q;
    assign DROP  = drop_q;

endmodule

// File: tb/tb_pbl_request_sequencer.sv
// Purpose : directed self-checking bench for pbl_request_sequencer.
// Latency : expected cycle positions are hand-derived from the debounce/hold timing.
// Backpressure: n/a.

module tb_pbl_request_sequencer;

    localparam int DB   = 4;
    localparam int HOLD = 8;
    localparam int PW   = 16;
`ifdef PBL_PAIR_WINDOW_EN
    localparam int LAUNCH = 1 + PW;
`else
    localparam int LAUNCH = 1;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] SW0, SW1;
    logic [1:0] KEY0, KEY1;
    logic [3:0] HH0, HH1;
    logic [1:0] B0, B1;
    logic       VALID;
    logic [1:0] PEND, DROP;

    int n_checks = 0;
    int n_errors = 0;

    pbl_request_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HOLD),
        .PAIR_WINDOW    (PW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .SW0  (SW0),
        .SW1  (SW1),
        .KEY0 (KEY0),
        .KEY1 (KEY1),
        .HH0  (HH0),
        .HH1  (HH1),
        .B0   (B0),
        .B1   (B1),
        .VALID(VALID),
        .PEND (PEND),
        .DROP (DROP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called on the cycle PEND[0] first reads 1 with user 1 idle: checks one
    // full round presenting user 0 alone, then the release cycle and the clear.
    task automatic check_round0(input logic [3:0] sw, input logic [1:0] key);
        KEY0 = 2'b11;
        step(LAUNCH - 1);
        chk("pre_valid", VALID, 0);
        step(1);
        chk("r_valid", VALID, 1);
        chk("r_hh0", HH0, sw);
        chk("r_b0", B0, key);
        chk("r_hh1", HH1, 4'b0000);
        chk("r_b1", B1, 2'b11);
        for (int k = 1; k < HOLD; k++) begin
            step(1);
            chk("r_hold", {VALID, HH0, B0, HH1, B1}, {1'b1, sw, key, 4'b0000, 2'b11});
        end
        step(1);
        chk("r_release", {VALID, HH0, B0, PEND}, {1'b0, 4'b0000, 2'b11, 2'b01});
        step(1);
        chk("r_cleared", {VALID, PEND}, {1'b0, 2'b00});
    endtask

    initial begin
        bit found;
        int bad;
        int vcnt;
        int rises;
        logic prev_v;

        rst  = 1'b1;
        SW0  = 4'b0000;
        SW1  = 4'b0000;
        KEY0 = 2'b11;
        KEY1 = 2'b11;
        step(3);

        // Reset state
        chk("rst_hh0", HH0, 4'b0000);
        chk("rst_hh1", HH1, 4'b0000);
        chk("rst_b0", B0, 2'b11);
        chk("rst_b1", B1, 2'b11);
        chk("rst_valid", VALID, 0);
        chk("rst_pend", PEND, 2'b00);
        chk("rst_drop", DROP, 2'b00);
        rst = 1'b0;
        step(3);

        // Bouncing key never captures; final stable change -> PEND after DB+3 cycles
        SW0 = 4'b0110;
        for (int i = 0; i < 10; i++) begin
            KEY0 = (i % 2 == 0) ? 2'b10 : 2'b11;
            step(2);
            chk("bounce_pend", PEND, 2'b00);
        end
        KEY0 = 2'b10;
        for (int i = 1; i < DB + 3; i++) begin
            step(1);
            chk("deb_early", PEND, 2'b00);
        end
        step(1);
        chk("deb_pend", PEND, 2'b01);
        check_round0(4'b0110, 2'b10);
        step(3);

        // Single user 0 request
        SW0  = 4'b1011;
        KEY0 = 2'b01;
        step(DB + 3);
        chk("u0_pend", PEND, 2'b01);
        check_round0(4'b1011, 2'b01);
        step(3);

`ifndef PBL_PAIR_WINDOW_EN
        // User 1 round; user 0 presses during it (waits for the next round),
        // then presses again while pending (dropped, stored code kept).
        SW1  = 4'b0101;
        KEY1 = 2'b10;
        step(3);
        SW0  = 4'b1110;
        KEY0 = 2'b01;
        step(4);                      // edge 7
        chk("d_pend1", PEND, 2'b10);
        KEY1 = 2'b11;
        step(1);                      // edge 8
        chk("d_round1", {VALID, HH1, B1, HH0, B0}, {1'b1, 4'b0101, 2'b10, 4'b0000, 2'b11});
        step(2);                      // edge 10
        chk("d_pend_both", PEND, 2'b11);
        chk("d_no_change", {HH0, B0}, {4'b0000, 2'b11});
        KEY0 = 2'b11;
        step(6);                      // edge 16
        chk("d_release1", VALID, 0);
        SW0  = 4'b0001;
        KEY0 = 2'b10;
        step(1);                      // edge 17
        chk("d_idle", {VALID, PEND}, {1'b0, 2'b01});
        step(1);                      // edge 18
        chk("d_round2", {VALID, HH0, B0, HH1, B1}, {1'b1, 4'b1110, 2'b01, 4'b0000, 2'b11});
        step(4);                      // edge 22
        chk("d_drop_early", DROP, 2'b00);
        step(1);                      // edge 23
        chk("d_drop", DROP, 2'b01);
        KEY0 = 2'b11;
        step(1);                      // edge 24
        chk("d_drop_end", DROP, 2'b00);
        chk("d_hh0_kept", HH0, 4'b1110);
        step(2);                      // edge 26
        chk("d_release2", VALID, 0);
        step(1);                      // edge 27
        chk("d_cleared", PEND, 2'b00);
        step(8);
`else
        // Pairing: user 1 presses 5 cycles after user 0 -> one joint round.
        SW0  = 4'b0011;
        KEY0 = 2'b10;
        step(5);
        SW1  = 4'b1100;
        KEY1 = 2'b01;
        step(2);                      // edge 7
        chk("p_pend0", PEND, 2'b01);
        KEY0 = 2'b11;
        step(5);                      // edge 12
        chk("p_pend_both", {VALID, PEND}, {1'b0, 2'b11});
        KEY1 = 2'b11;
        step(1);                      // edge 13
        chk("p_joint", {VALID, HH0, B0, HH1, B1}, {1'b1, 4'b0011, 2'b10, 4'b1100, 2'b01});
        vcnt   = 1;
        rises  = 0;
        prev_v = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step(1);
            if (VALID) vcnt++;
            if (VALID && !prev_v) rises++;
            prev_v = VALID;
        end
        chk("p_valid_len", vcnt, HOLD);
        chk("p_valid_once", rises, 0);
        chk("p_cleared", PEND, 2'b00);
        step(3);

        // Lone user 0: window expiry, and a second press dropped while waiting.
        SW0  = 4'b0111;
        KEY0 = 2'b01;
        step(7);                      // edge 7
        chk("w_pend", PEND, 2'b01);
        KEY0 = 2'b11;
        step(6);                      // edge 13
        SW0  = 4'b1000;
        KEY0 = 2'b10;
        step(7);                      // edge 20
        chk("w_drop", DROP, 2'b01);
        KEY0 = 2'b11;
        step(1);                      // edge 21
        chk("w_drop_end", DROP, 2'b00);
        step(2);                      // edge 23
        chk("w_not_yet", VALID, 0);
        step(1);                      // edge 24
        chk("w_present", {VALID, HH0, B0, HH1, B1}, {1'b1, 4'b0111, 2'b01, 4'b0000, 2'b11});
        step(9);                      // edge 33
        chk("w_cleared", {VALID, PEND}, {1'b0, 2'b00});
        step(8);
`endif

        // Reset on the third PRESENT cycle abandons the round.
        SW0  = 4'b1101;
        KEY0 = 2'b10;
        step(DB + 3);
        chk("x_pend", PEND, 2'b01);
        KEY0  = 2'b11;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            if (VALID === 1'b1) found = 1'b1;
        end
        chk("x_valid_seen", found, 1);
        step(2);
        rst = 1'b1;
        step(1);
        chk("x_rst_outs", {VALID, HH0, B0, HH1, B1, PEND, DROP},
            {1'b0, 4'b0000, 2'b11, 4'b0000, 2'b11, 2'b00, 2'b00});
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (VALID !== 1'b0 || PEND !== 2'b00) bad++;
        end
        chk("x_quiet", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
